// File: rtl/blink_sequencer.sv
// Command-driven LED blink sequencer: accepts {half-period, blink count} over valid/ready,
// runs that many ON/OFF phases from a programmable prescaler, then pulses done.
module blink_sequencer #(
    parameter int unsigned DIV_WIDTH   = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DIV_WIDTH-1:0] cmd_div,
    input  logic [CNT_WIDTH-1:0] cmd_count,
    input  logic                 abort,
    output logic                 led,
    output logic                 tick,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [DIV_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic                 r_led;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;

    logic                 w_run;
    logic                 w_tick;
    logic                 w_accept;

    // Phase end is decoded purely from registered state so tick has no input path.
    assign w_run    = (r_state == S_ON) || (r_state == S_OFF);
    assign w_tick   = w_run && (r_presc == (r_div - DIV_WIDTH'(1)));
    assign w_accept = cmd_valid && r_ready && (r_state == S_IDLE);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_div       <= '0;
            r_remaining <= '0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div       <= (cmd_div == '0) ? DIV_WIDTH'(DEFAULT_DIV) : cmd_div;
                        r_remaining <= cmd_count;
                        r_presc     <= '0;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                        if (cmd_count != '0) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_ON, S_OFF: begin
                    // Abort wins over any phase change, including the final OFF -> DONE.
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_led       <= 1'b0;
                        r_presc     <= '0;
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_state == S_ON) begin
                            r_state <= S_OFF;
                            r_led   <= 1'b0;
                        end else if (r_remaining > CNT_WIDTH'(1)) begin
                            r_state     <= S_ON;
                            r_led       <= 1'b1;
                            r_remaining <= r_remaining - CNT_WIDTH'(1);
                        end else begin
                            r_state     <= S_DONE;
                            r_remaining <= '0;
                            r_done      <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + DIV_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign led       = r_led;
    assign tick      = w_tick;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized bench for blink_sequencer against a cycle-indexed waveform model.
module tb_blink_sequencer;

    localparam int unsigned DW  = 6;
    localparam int unsigned CW  = 8;
    localparam int unsigned DEF = 4;

    logic          clk_in    = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] cmd_div   = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          abort     = 1'b0;
    logic          cmd_ready;
    logic          led;
    logic          tick;
    logic          busy;
    logic          done;
    logic [4:0]    obs;

    int n_cmp = 0;
    int n_mis = 0;

    blink_sequencer #(
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DEF),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_div  (cmd_div),
        .cmd_count(cmd_count),
        .abort    (abort),
        .led      (led),
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    // Observed vector: {led, tick, busy, done, cmd_ready}
    assign obs = {led, tick, busy, done, cmd_ready};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: observed %05b expected %05b", tag, got[4:0], want[4:0]);
        end
    endtask

    // Expected outputs in cycle k (k=1 is the cycle after the accepting edge).
    function automatic logic [4:0] ref_out(input int d, input int c, input int k);
        if (k <= 2 * d * c)
            return {(((k - 1) / d) % 2) == 0, (k % d) == 0, 1'b1, 1'b0, 1'b0};
        return 5'b00110;
    endfunction

    // Issue one command from an IDLE cycle; ab != 0 raises abort during cycle ab.
    task automatic run_cmd(input int div, input int cnt, input int ab);
        int d;
        int last;
        d    = (div == 0) ? int'(DEF) : div;
        last = (ab != 0) ? ab : 2 * d * cnt + 1;
        @(negedge clk_in);
        chk($sformatf("idle d=%0d c=%0d", div, cnt), 32'(obs), 32'(5'b00001));
        cmd_valid = 1'b1;
        cmd_div   = DW'(div);
        cmd_count = CW'(cnt);
        abort     = 1'($urandom_range(0, 1));
        @(posedge clk_in);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_in);
            chk($sformatf("d=%0d c=%0d ab=%0d cyc=%0d", div, cnt, ab, k),
                32'(obs), 32'(ref_out(d, cnt, k)));
            abort = (k == ab);
            if (k == last) begin
                cmd_valid = 1'b0;
                if (ab == 0) abort = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_div   = DW'($urandom_range(0, 63));
                cmd_count = CW'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        int div;
        int cnt;
        int d;
        int ab;

        // Reset held: everything low, including cmd_ready.
        repeat (5) begin
            @(negedge clk_in);
            chk("in_reset", 32'(obs), 32'(5'b00000));
        end
        rst = 1'b0;

        run_cmd(3, 2, 0);
        run_cmd(7, 0, 0);
        run_cmd(0, 1, 0);
        run_cmd(5, 3, 7);
        run_cmd(2, 1, 4);
        run_cmd(1, 3, 0);
        run_cmd(63, 1, 0);
        run_cmd(1, 255, 0);
        run_cmd(4, 2, 1);

        for (int i = 0; i < 30; i++) begin
            div = int'($urandom_range(0, 12));
            cnt = int'($urandom_range(0, 5));
            d   = (div == 0) ? int'(DEF) : div;
            ab  = 0;
            if (cnt != 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, 2 * d * cnt));
            run_cmd(div, cnt, ab);
        end

        // Asynchronous reset in the middle of an ON phase.
        @(negedge clk_in);
        cmd_valid = 1'b1;
        cmd_div   = DW'(3);
        cmd_count = CW'(4);
        abort     = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        chk("pre_rst_on", 32'(obs), 32'(5'b10100));
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(obs), 32'(5'b00000));
        repeat (3) begin
            @(negedge clk_in);
            chk("rst_hold", 32'(obs), 32'(5'b00000));
        end
        rst = 1'b0;

        run_cmd(2, 2, 0);
        @(negedge clk_in);
        chk("final_idle", 32'(obs), 32'(5'b00001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
